// File: rtl/mem_fill_arbiter_if.sv
// Cache-fill bus between the I/D caches, main memory and the fill arbiter.
//   master : arbiter side (takes miss requests and memory returns, drives
//            memory reads, data-array writes, done pulses and busy)
//   slave  : environment side (caches + memory)
interface mem_fill_arbiter_if;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_write;
  logic        d_write;
  logic        i_done;
  logic        d_done;
  logic        busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_data, fill_word, i_write, d_write,
           i_done, d_done, busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, fill_data, fill_word, i_write, d_write,
           i_done, d_done, busy
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-cache and D-cache block fills onto one main-memory read port.
// A granted fill issues eight word reads of a 16-byte block, steers each
// returned word into the owner's data array, then pulses the owner's done.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mem_fill_arbiter_if.master (miss requests, memory port, fill
//         writes, done pulses, busy stall)
module mem_fill_arbiter (
  input  logic                      clk,
  input  logic                      rst,
  mem_fill_arbiter_if.master        bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  issue_cnt;
  logic [2:0]  rcv_cnt;
  logic        owner_d;
  logic [15:0] base;
  logic        in_fill;

  assign in_fill = (state == FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      rcv_cnt   <= '0;
      owner_d   <= 1'b1;
      base      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          issue_cnt <= '0;
          rcv_cnt   <= '0;
          // D wins ties; owner and base are only latched here, so later
          // request or address changes cannot disturb a running fill.
          if (bus.d_miss) begin
            owner_d <= 1'b1;
            base    <= bus.d_miss_addr & 16'hFFF0;
          end else if (bus.i_miss) begin
            owner_d <= 1'b0;
            base    <= bus.i_miss_addr & 16'hFFF0;
          end
        end
        FILL: begin
          if (!issue_cnt[3]) issue_cnt <= issue_cnt + 4'd1;
          if (bus.mem_data_valid) rcv_cnt <= rcv_cnt + 3'd1;
        end
        DONE: begin
          issue_cnt <= '0;
          rcv_cnt   <= '0;
        end
        default: begin
          issue_cnt <= '0;
          rcv_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.fill_data = '0;
    bus.fill_word = '0;
    bus.i_write   = 1'b0;
    bus.d_write   = 1'b0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.busy      = 1'b0;

    case (state)
      IDLE:    if (bus.d_miss || bus.i_miss) state_next = FILL;
      FILL:    if (bus.mem_data_valid && rcv_cnt == 3'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Outputs are held at zero while rst is high, even in the cycle before
    // the synchronous reset has taken the state register back to IDLE.
    if (!rst) begin
      bus.busy = (state == FILL) || (state == DONE);
      if (in_fill && !issue_cnt[3]) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = base + {11'd0, issue_cnt[2:0], 1'b0};
      end
      if (in_fill && bus.mem_data_valid) begin
        bus.fill_data = bus.mem_data;
        bus.fill_word = rcv_cnt;
        bus.d_write   = owner_d;
        bus.i_write   = !owner_d;
      end
      if (state == DONE) begin
        bus.d_done = owner_d;
        bus.i_done = !owner_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
module tb_mem_fill_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mem_fill_arbiter_if bus ();

  mem_fill_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Memory model: fixed 4-cycle latency, pipelined, data = addr ^ 16'hBEEF.
  logic        pv [4];
  logic [15:0] pa [4];
  logic        pipe_valid = 1'b0;
  logic [15:0] pipe_data  = '0;
  logic        spur = 1'b0;

  initial for (int k = 0; k < 4; k++) begin pv[k] = 1'b0; pa[k] = '0; end

  always @(negedge clk) begin
    for (int k = 3; k > 0; k--) begin pv[k] = pv[k-1]; pa[k] = pa[k-1]; end
    pv[0] = bus.mem_en;
    pa[0] = bus.mem_addr;
  end

  always @(posedge clk) begin
    #1;
    pipe_valid = pv[3];
    pipe_data  = pa[3] ^ 16'hBEEF;
  end

  assign bus.mem_data_valid = pipe_valid | spur;
  assign bus.mem_data       = spur ? 16'hDEAD : pipe_data;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs in cycle c for a fill granted in cycle g.
  task automatic check_win(input string s, input int c, input int g,
                           input logic [15:0] base, input logic own_d);
    int          r;
    logic        en, wr, dn, bz;
    logic [15:0] ea, ed;
    logic [2:0]  ew;
    r  = c - g;
    bz = (r >= 1 && r <= 13);
    en = (r >= 1 && r <= 8);
    wr = (r >= 5 && r <= 12);
    dn = (r == 13);
    ea = en ? base + 16'(2 * (r - 1)) : 16'h0000;
    ew = wr ? 3'(r - 5) : 3'd0;
    ed = wr ? ((base + 16'(2 * (r - 5))) ^ 16'hBEEF) : 16'h0000;
    chk($sformatf("%s c%0d busy", s, c),      16'(bus.busy),      16'(bz));
    chk($sformatf("%s c%0d mem_en", s, c),    16'(bus.mem_en),    16'(en));
    chk($sformatf("%s c%0d mem_addr", s, c),  bus.mem_addr,       ea);
    chk($sformatf("%s c%0d d_write", s, c),   16'(bus.d_write),   16'(wr && own_d));
    chk($sformatf("%s c%0d i_write", s, c),   16'(bus.i_write),   16'(wr && !own_d));
    chk($sformatf("%s c%0d fill_word", s, c), 16'(bus.fill_word), 16'(ew));
    chk($sformatf("%s c%0d fill_data", s, c), bus.fill_data,      ed);
    chk($sformatf("%s c%0d d_done", s, c),    16'(bus.d_done),    16'(dn && own_d));
    chk($sformatf("%s c%0d i_done", s, c),    16'(bus.i_done),    16'(dn && !own_d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    bus.i_miss      = 1'b1;
    bus.i_miss_addr = 16'h0017;
    bus.d_miss      = 1'b0;
    bus.d_miss_addr = '0;
    step();

    // Reset held with a pending I miss: all outputs zero; first edge after
    // release grants the request.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); check_win("rst", c, -100, 16'h0000, 1'b0);
      step();
    end
    rst = 1'b0;
    for (int c = 3; c <= 17; c++) begin
      @(negedge clk); check_win("s0", c, 3, 16'h0010, 1'b0);
      step();
      if (c == 16) bus.i_miss = 1'b0;
    end

    // Single D miss at 0x1234.
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h1234;
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk); check_win("s1", c, 0, 16'h1230, 1'b1);
      step();
      if (c == 13) bus.d_miss = 1'b0;
    end

    // Simultaneous misses: D first, I granted in the IDLE cycle after DONE.
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h0040;
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0200;
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      if (c <= 13) check_win("s2", c, 0, 16'h0040, 1'b1);
      else         check_win("s2", c, 14, 16'h0200, 1'b0);
      step();
      if (c == 13) bus.d_miss = 1'b0;
      if (c == 27) bus.i_miss = 1'b0;
    end

    // I request dropped and address changed mid-fill: fill still completes.
    bus.i_miss = 1'b1; bus.i_miss_addr = 16'h0ABC;
    for (int c = 0; c <= 15; c++) begin
      @(negedge clk); check_win("s3", c, 0, 16'h0AB0, 1'b0);
      step();
      if (c == 2) begin bus.i_miss = 1'b0; bus.i_miss_addr = 16'hFFFF; end
    end

    // Reset mid-fill: outputs zero, late memory returns write nothing.
    bus.d_miss = 1'b1; bus.d_miss_addr = 16'h5678;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk); check_win("s4", c, 0, 16'h5670, 1'b1);
      step();
    end
    rst = 1'b1; bus.d_miss = 1'b0;
    @(negedge clk); check_win("s4rst", 6, -100, 16'h0000, 1'b0);
    step();
    rst = 1'b0;
    for (int c = 7; c <= 12; c++) begin
      @(negedge clk); check_win("s4post", c, -100, 16'h0000, 1'b0);
      step();
    end

    // Spurious memory return while idle.
    spur = 1'b1;
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk); check_win("s5", c, -100, 16'h0000, 1'b0);
      step();
      if (c == 1) spur = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
